// File: rtl/video_timing_gen.sv
// Raster timing generator: prescaled pixel tick, h/v position counters, and
// DE/HSYNC/VSYNC delayed through a short shift register for pipeline alignment.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned H_FP     = 8,
  parameter int unsigned H_SYNC   = 32,
  parameter int unsigned H_BP     = 40,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 6,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned SYNC_DLY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  output logic        o_pix_enable,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_frame,
  output logic        o_de,
  output logic        o_hsync,
  output logic        o_vsync
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  PscMax   = 4'(CLK_DIV - 1);
  localparam logic [11:0] HMax     = 12'(H_TOTAL - 1);
  localparam logic [11:0] VMax     = 12'(V_TOTAL - 1);
  // 13-bit window bounds so an end equal to 4096 still compares correctly.
  localparam logic [12:0] HActive  = 13'(H_ACTIVE);
  localparam logic [12:0] VActive  = 13'(V_ACTIVE);
  localparam logic [12:0] HsStart  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HsEnd    = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VsStart  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VsEnd    = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HsActive = (HS_POL != 0);
  localparam logic        VsActive = (VS_POL != 0);

  logic [3:0]  psc_q, psc_d;
  logic [11:0] h_q, h_d, v_q, v_d;
  logic        pix_q, pix_d;
  logic        frame_q, frame_d;
  logic        tick, h_wrap, v_wrap;
  logic        de_n, hs_n, vs_n;

  // Each stage holds {de, hsync, vsync} as active-high flags; 0 is the idle level.
  logic [2:0]  dly_q [SYNC_DLY+1];
  logic [2:0]  dly_d [SYNC_DLY+1];

  always_comb begin
    tick    = i_enable && (psc_q == PscMax);
    h_wrap  = (h_q == HMax);
    v_wrap  = (v_q == VMax);

    psc_d   = psc_q;
    h_d     = h_q;
    v_d     = v_q;
    pix_d   = tick;
    frame_d = tick && h_wrap && v_wrap;

    if (i_enable) begin
      psc_d = tick ? 4'd0 : psc_q + 4'd1;
    end
    if (tick) begin
      h_d = h_wrap ? 12'd0 : h_q + 12'd1;
      if (h_wrap) begin
        v_d = v_wrap ? 12'd0 : v_q + 12'd1;
      end
    end

    // Decode from next-state counters so stage 0 lines up with o_x/o_y.
    de_n = ({1'b0, h_d} < HActive) && ({1'b0, v_d} < VActive);
    hs_n = ({1'b0, h_d} >= HsStart) && ({1'b0, h_d} < HsEnd);
    vs_n = ({1'b0, v_d} >= VsStart) && ({1'b0, v_d} < VsEnd);

    dly_d[0] = {de_n, hs_n, vs_n};
    for (int unsigned i = 1; i <= SYNC_DLY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      pix_q   <= 1'b0;
      frame_q <= 1'b0;
      for (int unsigned i = 0; i <= SYNC_DLY; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      psc_q   <= psc_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pix_q   <= pix_d;
      frame_q <= frame_d;
      for (int unsigned i = 0; i <= SYNC_DLY; i++) begin
        dly_q[i] <= dly_d[i];
      end
    end
  end

  always_comb begin
    o_pix_enable = pix_q;
    o_x          = h_q;
    o_y          = v_q;
    o_frame      = frame_q;
    o_de         = dly_q[SYNC_DLY][2];
    o_hsync      = dly_q[SYNC_DLY][1] ? HsActive : ~HsActive;
    o_vsync      = dly_q[SYNC_DLY][0] ? VsActive : ~VsActive;
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 14x7 raster: line/frame timing, sync
// windows, freeze/resume, mid-frame reset, and the CLK_DIV=1/SYNC_DLY=0 corner.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;

  logic        pix, frame, de, hs, vs;
  logic [11:0] x, y;
  logic        pix1, frame1, de1, hs1, vs1;
  logic [11:0] x1, y1;

  int n_tests = 0;
  int n_fail  = 0;
  int frames  = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CLK_DIV(2), .SYNC_DLY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(en),
    .o_pix_enable(pix), .o_x(x), .o_y(y), .o_frame(frame),
    .o_de(de), .o_hsync(hs), .o_vsync(vs)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CLK_DIV(1), .SYNC_DLY(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .i_enable(en),
    .o_pix_enable(pix1), .o_x(x1), .o_y(y1), .o_frame(frame1),
    .o_de(de1), .o_hsync(hs1), .o_vsync(vs1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expected sync levels for a raster position (both syncs active-low).
  function automatic logic exp_hs(input int px);
    return !(px >= 10 && px < 12);
  endfunction
  function automatic logic exp_vs(input int py);
    return !(py == 5);
  endfunction
  function automatic logic exp_de(input int px, input int py);
    return (px < 8) && (py < 4);
  endfunction

  task automatic check_sync(input string tag, input int p);
    check({tag, "_de"}, 32'(de), 32'(exp_de(p % 14, p / 14)));
    check({tag, "_hs"}, 32'(hs), 32'(exp_hs(p % 14)));
    check({tag, "_vs"}, 32'(vs), 32'(exp_vs(p / 14)));
  endtask

  // One tick period of dut: idle clk then tick clk. Position after tick k is (k+1) mod 98.
  task automatic run_ticks(input int k0, input int n);
    int p0, p1;
    for (int k = k0; k < k0 + n; k++) begin
      p0 = k % 98;
      p1 = (k + 1) % 98;
      step();
      check("idle_pix", 32'(pix), 32'd0);
      check("idle_frame", 32'(frame), 32'd0);
      check("idle_x", 32'(x), 32'(p0 % 14));
      check("idle_y", 32'(y), 32'(p0 / 14));
      if (k > 0) check_sync("idle", p0);
      step();
      check("tick_pix", 32'(pix), 32'd1);
      check("tick_x", 32'(x), 32'(p1 % 14));
      check("tick_y", 32'(y), 32'(p1 / 14));
      check("tick_frame", 32'(frame), 32'(p1 == 0));
      if (frame) frames++;
      check_sync("tick", p0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_y"}, 32'(y), 32'd0);
    check({tag, "_pix"}, 32'(pix), 32'd0);
    check({tag, "_frame"}, 32'(frame), 32'd0);
    check({tag, "_de"}, 32'(de), 32'd0);
    check({tag, "_hs"}, 32'(hs), 32'd1);
    check({tag, "_vs"}, 32'(vs), 32'd1);
    check({tag, "_x1"}, 32'(x1), 32'd0);
    check({tag, "_pix1"}, 32'(pix1), 32'd0);
    check({tag, "_hs1"}, 32'(hs1), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) step();
    check_reset_vals("rst");

    // Line timing, sync windows and two full frames.
    rst_n = 1'b1;
    run_ticks(0, 201);
    check("frame_cnt", 32'(frames), 32'd2);

    // Freeze at o_x=5 for 37 clk.
    en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      step();
      check("frz_pix", 32'(pix), 32'd0);
      check("frz_frame", 32'(frame), 32'd0);
      check("frz_x", 32'(x), 32'd5);
      check("frz_y", 32'(y), 32'd0);
      check_sync("frz", 5);
    end
    en = 1'b1;
    run_ticks(201, 46);
    check("pre_rst_x", 32'(x), 32'd9);
    check("pre_rst_y", 32'(y), 32'd3);

    // Mid-frame reset at (9,3).
    step();
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    step();
    check("mid_rst_frame", 32'(frame), 32'd0);
    rst_n = 1'b1;
    step();
    check("rel_pix0", 32'(pix), 32'd0);
    check("rel_x0", 32'(x), 32'd0);
    step();
    check("rel_pix1", 32'(pix), 32'd1);
    check("rel_x1", 32'(x), 32'd1);
    check("rel_y1", 32'(y), 32'd0);
    check("rel_frame", 32'(frame), 32'd0);

    // CLK_DIV=1, SYNC_DLY=0 instance: tick every clk, syncs aligned with o_x.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("d1_pix", 32'(pix1), 32'd1);
      check("d1_x", 32'(x1), 32'((i + 1) % 14));
      check("d1_y", 32'(y1), 32'((i + 1) / 14));
      check("d1_hs", 32'(hs1), 32'(exp_hs((i + 1) % 14)));
      check("d1_de", 32'(de1), 32'(exp_de((i + 1) % 14, (i + 1) / 14)));
      check("d1_vs", 32'(vs1), 32'd1);
      check("d1_frame", 32'(frame1), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
